dzcpu_useq: RTL and testbench
=============================

# dzcpu_useq

Parametrised microcode sequencer for the dzcpu core. Replaces fixed flow-index walking with a micro-PC that supports sequential advance, conditional end-of-flow, CB-prefix dispatch, micro-subroutine call/return on a parametrised stack, memory stalls, and optional interrupt-flow entry. Sits between the opcode/CB flow LUTs and the microcode ROM (both external, combinational) and issues one registered micro-op per cycle to the datapath.

## Interface

- UOP_W, 13: micro-op word width; top 3 bits are the NXT field, the rest pass through unchanged.
- UADDR_W, 8: micro-address width.
- STACK_DEPTH, 4: micro-return stack entries (≥1).
- INT_FLOW_IDX, 8'd200: ROM entry address of the interrupt flow.

- iClock  in  1  clock, all state rises on posedge.
- iReset  in  1  asynchronous, active-high reset.
- iFlowIdx  in  UADDR_W  entry address from base opcode LUT.
- iCbFlowIdx  in  UADDR_W  entry address from CB LUT.
- iStart  in  1  opcode fetched, flow may begin.
- oStartAck  out  1  one-cycle pulse: iStart consumed.
- iZ  in  1  zero flag.
- iStall  in  1  datapath/memory not ready; freeze.
- iIntReq  in  1  interrupt pending (used only with USEQ_INT_EN).
- oIntAck  out  1  one-cycle pulse: interrupt flow entered.
- oUaddr  out  UADDR_W  ROM address (= micro-PC, combinational).
- iUop  in  UOP_W  ROM data for oUaddr.
- oUop  out  UOP_W  registered micro-op to datapath.
- oUopValid  out  1  oUop valid this cycle.
- oIdle  out  1  no flow in progress.
- oStackErr  out  1  sticky stack overflow/underflow.

## Operation

- States: IDLE, RUN. NXT = iUop[UOP_W-1 -: 3]; target T = iUop[UADDR_W-1:0].
- IDLE: oIdle=1. If iIntReq (macro on): upc<=INT_FLOW_IDX, oIntAck=1, ->RUN; iStart not acked. Else if iStart: upc<=iFlowIdx, oStartAck=1, ->RUN.
- RUN, iStall=0: oUop<=iUop, oUopValid<=1, then by NXT:
  - 0 SEQ: upc+1.
  - 1 EOF: ->IDLE.
  - 2 EOFZ: iZ=1 ->IDLE, else upc+1.
  - 3 EOFNZ: iZ=0 ->IDLE, else upc+1.
  - 4 JCB: upc<=iCbFlowIdx.
  - 5 CALL: push upc+1, upc<=T. Stack full: oStackErr<=1, treat as SEQ.
  - 6 RET: pop into upc. Stack empty: oStackErr<=1, treat as EOF.
  - 7 JMP: upc<=T.
- RUN, iStall=1: no state, upc, stack change; oUopValid<=0; oUop holds.
- upc+1 wraps modulo 2^UADDR_W.
- Entering IDLE (EOF/EOFZ/EOFNZ/underflow) clears stack pointer to 0.
- oStackErr clears only on reset.

## Timing

- Reset (async): state IDLE, upc=0, sp=0, oUop=0, oUopValid=0, oIdle=1, oStartAck=0, oIntAck=0, oStackErr=0.
- Start latency: iStart sampled at edge N; oUaddr=iFlowIdx after N; first oUopValid=1 after edge N+1.
- One micro-op per non-stalled RUN cycle; an n-word flow with no stalls occupies n cycles; oIdle=1 the cycle after the EOF word is issued.
- iStart/iIntReq only sampled in IDLE; the cycle after EOF issue is IDLE, so back-to-back flows have one bubble.
- iIntReq and iStart together in IDLE: interrupt wins; iStart must be held and is acked on the next IDLE.
- oStartAck/oIntAck are registered single-cycle pulses coincident with the IDLE->RUN edge.
- Reset asserted mid-flow: immediate return to reset values; no partial uop issued.

## Configuration

- USEQ_INT_EN defined: iIntReq sampled in IDLE as above; oIntAck driven.
- Undefined: iIntReq ignored, oIntAck tied 0, INT_FLOW_IDX unused; no interrupt logic synthesised.

## Test plan

- Flow at 5 (words 5..8 SEQ,SEQ,SEQ,EOF), iStart with iFlowIdx=5 -> oStartAck pulse, oUop = ROM[5..8] on 4 consecutive cycles, oIdle=1 next cycle.
- EOFZ at 19 with iZ=1 -> flow ends after word 19; with iZ=0 -> words 20..22 issued then EOF.
- JCB at 15, iCbFlowIdx=16, word 16 EOF -> oUop sequence ROM[13],ROM[14],ROM[15],ROM[16], idle.
- STACK_DEPTH=2, nested CALLs three deep -> third CALL sets oStackErr, falls through as SEQ; RET on empty stack -> oStackErr stays 1, flow ends.
- iStall high 3 cycles mid-flow -> oUopValid=0 for 3 cycles, oUaddr frozen, no word skipped or duplicated.
- USEQ_INT_EN, iIntReq and iStart together in IDLE -> oIntAck, oUaddr=200, no oStartAck; after interrupt EOF, iStart acked. Reset mid-flow -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dzcpu_useq.sv
// rtl/dzcpu_useq.sv - dzcpu micro-PC sequencer; define USEQ_INT_EN to enable interrupt-flow entry
module dzcpu_useq #(
   parameter int                 UOP_W        = 13,
   parameter int                 UADDR_W      = 8,
   parameter int                 STACK_DEPTH  = 4,
   parameter logic [UADDR_W-1:0] INT_FLOW_IDX = 8'd200
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic [UADDR_W-1:0] iFlowIdx,
   input  logic [UADDR_W-1:0] iCbFlowIdx,
   input  logic               iStart,
   output logic               oStartAck,
   input  logic               iZ,
   input  logic               iStall,
   input  logic               iIntReq,
   output logic               oIntAck,
   output logic [UADDR_W-1:0] oUaddr,
   input  logic [UOP_W-1:0]   iUop,
   output logic [UOP_W-1:0]   oUop,
   output logic               oUopValid,
   output logic               oIdle,
   output logic               oStackErr
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] NXT_SEQ   = 3'd0;
   localparam logic [2:0] NXT_EOF   = 3'd1;
   localparam logic [2:0] NXT_EOFZ  = 3'd2;
   localparam logic [2:0] NXT_EOFNZ = 3'd3;
   localparam logic [2:0] NXT_JCB   = 3'd4;
   localparam logic [2:0] NXT_CALL  = 3'd5;
   localparam logic [2:0] NXT_RET   = 3'd6;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t               state_q, state_d;
   logic [UADDR_W-1:0]   upc_q, upc_d;
   logic [SP_W-1:0]      sp_q, sp_d;
   logic [UADDR_W-1:0]   stack_q [STACK_DEPTH];
   logic [UADDR_W-1:0]   stack_d [STACK_DEPTH];
   logic [UOP_W-1:0]     uop_q, uop_d;
   logic                 uop_valid_q, uop_valid_d;
   logic                 start_ack_q, start_ack_d;
   logic                 stack_err_q, stack_err_d;

   logic [2:0]           nxt;
   logic [UADDR_W-1:0]   tgt;
   logic [UADDR_W-1:0]   upc_inc;
   logic [SP_W-1:0]      sp_dec;
   logic [IDX_W-1:0]     push_idx;
   logic [IDX_W-1:0]     pop_idx;
   logic                 stack_full;
   logic                 stack_empty;

   assign nxt         = iUop[UOP_W-1 -: 3];
   assign tgt         = iUop[UADDR_W-1:0];
   assign upc_inc     = upc_q + 1'b1;
   assign sp_dec      = sp_q - 1'b1;
   assign push_idx    = sp_q[IDX_W-1:0];
   assign pop_idx     = sp_dec[IDX_W-1:0];
   assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp_q == '0);

`ifdef USEQ_INT_EN
   logic int_ack_q, int_ack_d;
   assign oIntAck = int_ack_q;
`else
   logic [UADDR_W:0] unused_int;
   assign unused_int = {iIntReq, INT_FLOW_IDX};
   assign oIntAck    = 1'b0;
`endif

   // Next-state: flow entry in IDLE, NXT-field decode in RUN, full freeze on stall
   always_comb begin
      state_d     = state_q;
      upc_d       = upc_q;
      sp_d        = sp_q;
      stack_d     = stack_q;
      uop_d       = uop_q;
      uop_valid_d = 1'b0;
      start_ack_d = 1'b0;
      stack_err_d = stack_err_q;
`ifdef USEQ_INT_EN
      int_ack_d   = 1'b0;
`endif
      if (state_q == ST_IDLE) begin
`ifdef USEQ_INT_EN
         if (iIntReq) begin
            upc_d     = INT_FLOW_IDX;
            int_ack_d = 1'b1;
            state_d   = ST_RUN;
         end else
`endif
         if (iStart) begin
            upc_d       = iFlowIdx;
            start_ack_d = 1'b1;
            state_d     = ST_RUN;
         end
      end else if (!iStall) begin
         uop_d       = iUop;
         uop_valid_d = 1'b1;
         case (nxt)
            NXT_SEQ: upc_d = upc_inc;
            NXT_EOF: begin
               state_d = ST_IDLE;
               sp_d    = '0;
            end
            NXT_EOFZ: begin
               if (iZ) begin
                  state_d = ST_IDLE;
                  sp_d    = '0;
               end else begin
                  upc_d = upc_inc;
               end
            end
            NXT_EOFNZ: begin
               if (!iZ) begin
                  state_d = ST_IDLE;
                  sp_d    = '0;
               end else begin
                  upc_d = upc_inc;
               end
            end
            NXT_JCB: upc_d = iCbFlowIdx;
            NXT_CALL: begin
               // overflow keeps the flow alive by falling through sequentially
               if (stack_full) begin
                  stack_err_d = 1'b1;
                  upc_d       = upc_inc;
               end else begin
                  stack_d[push_idx] = upc_inc;
                  sp_d              = sp_q + 1'b1;
                  upc_d             = tgt;
               end
            end
            NXT_RET: begin
               // underflow has no return target, so the flow is terminated
               if (stack_empty) begin
                  stack_err_d = 1'b1;
                  state_d     = ST_IDLE;
                  sp_d        = '0;
               end else begin
                  upc_d = stack_q[pop_idx];
                  sp_d  = sp_dec;
               end
            end
            default: upc_d = tgt;
         endcase
      end
   end

   // State, micro-PC, return stack and registered outputs
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q     <= ST_IDLE;
         upc_q       <= '0;
         sp_q        <= '0;
         uop_q       <= '0;
         uop_valid_q <= 1'b0;
         start_ack_q <= 1'b0;
         stack_err_q <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
`ifdef USEQ_INT_EN
         int_ack_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         upc_q       <= upc_d;
         sp_q        <= sp_d;
         uop_q       <= uop_d;
         uop_valid_q <= uop_valid_d;
         start_ack_q <= start_ack_d;
         stack_err_q <= stack_err_d;
         stack_q     <= stack_d;
`ifdef USEQ_INT_EN
         int_ack_q   <= int_ack_d;
`endif
      end
   end

   assign oUaddr    = upc_q;
   assign oUop      = uop_q;
   assign oUopValid = uop_valid_q;
   assign oIdle     = (state_q == ST_IDLE);
   assign oStartAck = start_ack_q;
   assign oStackErr = stack_err_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb/tb_dzcpu_useq.sv - scoreboard bench for dzcpu_useq with an interpreting ROM model
module tb_dzcpu_useq;

   localparam int DEPTH = 2;

   logic        iClock;
   logic        iReset;
   logic [7:0]  iFlowIdx;
   logic [7:0]  iCbFlowIdx;
   logic        iStart;
   logic        oStartAck;
   logic        iZ;
   logic        iStall;
   logic        iIntReq;
   logic        oIntAck;
   logic [7:0]  oUaddr;
   logic [12:0] iUop;
   logic [12:0] oUop;
   logic        oUopValid;
   logic        oIdle;
   logic        oStackErr;

   logic [12:0] rom [256];
   logic [12:0] exp_w [$];
   bit          exp_last [$];
   logic        exp_err;
   int          n_checks;
   int          n_pass;
   bit          rnd_en;
   logic        rnd_stall;
   logic        dir_stall;

   dzcpu_useq #(
      .UOP_W(13),
      .UADDR_W(8),
      .STACK_DEPTH(DEPTH),
      .INT_FLOW_IDX(8'd200)
   ) dut (
      .iClock(iClock),
      .iReset(iReset),
      .iFlowIdx(iFlowIdx),
      .iCbFlowIdx(iCbFlowIdx),
      .iStart(iStart),
      .oStartAck(oStartAck),
      .iZ(iZ),
      .iStall(iStall),
      .iIntReq(iIntReq),
      .oIntAck(oIntAck),
      .oUaddr(oUaddr),
      .iUop(iUop),
      .oUop(oUop),
      .oUopValid(oUopValid),
      .oIdle(oIdle),
      .oStackErr(oStackErr)
   );

   assign iUop   = rom[oUaddr];
   assign iStall = dir_stall | rnd_stall;

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [12:0] mkw(input logic [2:0] nxt, input logic [7:0] t);
      return {nxt, 2'($urandom), t};
   endfunction

   // Walk the ROM as the flow rules describe, queueing every word the DUT must issue
   task automatic model_flow(input logic [7:0] start, input logic [7:0] cb, input logic z);
      logic [7:0]  pc;
      logic [7:0]  stk [$];
      logic [12:0] w;
      bit          done;
      int          steps;
      pc = start;
      done = 0;
      steps = 0;
      while (!done && steps < 100) begin
         w = rom[pc];
         steps++;
         case (w[12:10])
            3'd0: pc = pc + 8'd1;
            3'd1: done = 1;
            3'd2: if (z) done = 1; else pc = pc + 8'd1;
            3'd3: if (!z) done = 1; else pc = pc + 8'd1;
            3'd4: pc = cb;
            3'd5: begin
               if (stk.size() == DEPTH) begin
                  exp_err = 1'b1;
                  pc = pc + 8'd1;
               end else begin
                  stk.push_back(pc + 8'd1);
                  pc = w[7:0];
               end
            end
            3'd6: begin
               if (stk.size() == 0) begin
                  exp_err = 1'b1;
                  done = 1;
               end else begin
                  pc = stk.pop_back();
               end
            end
            default: pc = w[7:0];
         endcase
         exp_w.push_back(w);
         exp_last.push_back(done);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge iClock);
      while (!oIdle && k < 300) begin
         @(negedge iClock);
         k++;
      end
      check("flow_done_idle", 32'(oIdle), 32'd1);
   endtask

   task automatic run_flow(input logic [7:0] start, input logic [7:0] cb, input logic z,
                           input bit rnd, input bit chk_lat);
      wait_idle();
      model_flow(start, cb, z);
      iFlowIdx   = start;
      iCbFlowIdx = cb;
      iZ         = z;
      rnd_en     = rnd;
      iStart     = 1'b1;
      @(posedge iClock); #1;
      check("start_ack", 32'(oStartAck), 32'd1);
      check("start_uaddr", 32'(oUaddr), 32'(start));
      @(negedge iClock);
      iStart   = 1'b0;
      iFlowIdx = 8'($urandom);
      if (chk_lat) begin
         @(posedge iClock); #1;
         check("first_uop_valid", 32'(oUopValid), 32'd1);
      end
      wait_idle();
      rnd_en = 0;
      check("stack_err", 32'(oStackErr), 32'(exp_err));
   endtask

   // Random stall generator, updated just after each rising edge
   initial begin
      rnd_stall = 1'b0;
      forever begin
         @(posedge iClock);
         #2;
         rnd_stall = rnd_en && ($urandom_range(0, 2) == 0);
      end
   end

   // Scoreboard monitor: every issued micro-op must match the head of the expected queue
   always @(negedge iClock) begin
      logic [12:0] w;
      bit          l;
      if (!iReset && oUopValid) begin
         if (exp_w.size() == 0) begin
            check("uop_expected", 32'(exp_w.size()), 32'd1);
         end else begin
            w = exp_w.pop_front();
            l = exp_last.pop_front();
            check("uop_word", 32'(oUop), 32'(w));
            check("uop_idle_after_eof", 32'(oIdle), 32'(l));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      logic [7:0] entries [8];
      logic [7:0] cbs [3];
      int         k;
      n_checks   = 0;
      n_pass     = 0;
      exp_err    = 1'b0;
      rnd_en     = 0;
      dir_stall  = 1'b0;
      iReset     = 1'b1;
      iFlowIdx   = '0;
      iCbFlowIdx = '0;
      iStart     = 1'b0;
      iZ         = 1'b0;
      iIntReq    = 1'b0;
      entries = '{8'd5, 8'd13, 8'd19, 8'd30, 8'd80, 8'd110, 8'd255, 8'd40};
      cbs     = '{8'd16, 8'd5, 8'd30};

      for (int i = 0; i < 256; i++) rom[i] = mkw(3'd1, 8'($urandom));
      rom[5]   = mkw(3'd0, 8'($urandom));
      rom[6]   = mkw(3'd0, 8'($urandom));
      rom[7]   = mkw(3'd0, 8'($urandom));
      rom[13]  = mkw(3'd0, 8'($urandom));
      rom[14]  = mkw(3'd0, 8'($urandom));
      rom[15]  = mkw(3'd4, 8'($urandom));
      rom[19]  = mkw(3'd2, 8'($urandom));
      rom[20]  = mkw(3'd0, 8'($urandom));
      rom[21]  = mkw(3'd0, 8'($urandom));
      rom[30]  = mkw(3'd3, 8'($urandom));
      rom[40]  = mkw(3'd5, 8'd50);
      rom[41]  = mkw(3'd6, 8'($urandom));
      rom[50]  = mkw(3'd5, 8'd60);
      rom[51]  = mkw(3'd6, 8'($urandom));
      rom[60]  = mkw(3'd5, 8'd70);
      rom[61]  = mkw(3'd6, 8'($urandom));
      rom[80]  = mkw(3'd5, 8'd90);
      rom[81]  = mkw(3'd7, 8'd100);
      rom[90]  = mkw(3'd0, 8'($urandom));
      rom[91]  = mkw(3'd6, 8'($urandom));
      rom[110] = mkw(3'd5, 8'd120);
      rom[200] = mkw(3'd0, 8'($urandom));
      rom[255] = mkw(3'd0, 8'($urandom));

      repeat (3) @(posedge iClock);
      #1;
      check("rst_idle", 32'(oIdle), 32'd1);
      check("rst_valid", 32'(oUopValid), 32'd0);
      check("rst_uop", 32'(oUop), 32'd0);
      check("rst_uaddr", 32'(oUaddr), 32'd0);
      check("rst_start_ack", 32'(oStartAck), 32'd0);
      check("rst_int_ack", 32'(oIntAck), 32'd0);
      check("rst_stack_err", 32'(oStackErr), 32'd0);
      @(negedge iClock);
      iReset = 1'b0;

      run_flow(8'd5, 8'd16, 1'b0, 0, 1);
      run_flow(8'd19, 8'd16, 1'b1, 0, 0);
      run_flow(8'd19, 8'd16, 1'b0, 0, 0);
      run_flow(8'd30, 8'd16, 1'b0, 0, 0);
      run_flow(8'd30, 8'd16, 1'b1, 0, 0);
      run_flow(8'd13, 8'd16, 1'b0, 0, 0);
      run_flow(8'd80, 8'd16, 1'b0, 0, 0);
      run_flow(8'd255, 8'd16, 1'b0, 0, 0);
      run_flow(8'd110, 8'd16, 1'b0, 0, 0);

      // three-cycle stall in the middle of the 5..8 flow
      wait_idle();
      model_flow(8'd5, 8'd16, 1'b0);
      iFlowIdx = 8'd5;
      iStart   = 1'b1;
      @(posedge iClock); #1;
      check("stall_start_ack", 32'(oStartAck), 32'd1);
      @(negedge iClock);
      iStart = 1'b0;
      @(posedge iClock); #1;
      check("stall_pre_valid", 32'(oUopValid), 32'd1);
      check("stall_pre_uaddr", 32'(oUaddr), 32'd6);
      @(negedge iClock);
      dir_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge iClock); #1;
         check("stall_valid", 32'(oUopValid), 32'd0);
         check("stall_uaddr", 32'(oUaddr), 32'd6);
      end
      @(negedge iClock);
      dir_stall = 1'b0;
      wait_idle();

      // interrupt request and start presented together
      wait_idle();
`ifdef USEQ_INT_EN
      model_flow(8'd200, 8'd16, 1'b0);
`endif
      model_flow(8'd5, 8'd16, 1'b0);
      iFlowIdx   = 8'd5;
      iCbFlowIdx = 8'd16;
      iZ         = 1'b0;
      iStart     = 1'b1;
      iIntReq    = 1'b1;
      @(posedge iClock); #1;
`ifdef USEQ_INT_EN
      check("int_ack", 32'(oIntAck), 32'd1);
      check("int_no_start_ack", 32'(oStartAck), 32'd0);
      check("int_uaddr", 32'(oUaddr), 32'd200);
      @(negedge iClock);
      iIntReq = 1'b0;
      k = 0;
      @(posedge iClock); #1;
      while (!oStartAck && k < 50) begin
         @(posedge iClock); #1;
         k++;
      end
      check("held_start_ack", 32'(oStartAck), 32'd1);
      check("held_start_uaddr", 32'(oUaddr), 32'd5);
      @(negedge iClock);
      iStart = 1'b0;
`else
      check("int_ack_tied", 32'(oIntAck), 32'd0);
      check("int_ignored_start_ack", 32'(oStartAck), 32'd1);
      check("int_ignored_uaddr", 32'(oUaddr), 32'd5);
      @(negedge iClock);
      iStart  = 1'b0;
      iIntReq = 1'b0;
`endif
      wait_idle();

      run_flow(8'd40, 8'd16, 1'b0, 0, 0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 256; i++) rom[i][9:8] = 2'($urandom);
         run_flow(entries[$urandom_range(0, 7)], cbs[$urandom_range(0, 2)],
                  1'($urandom_range(0, 1)), 1, 0);
      end

      // asynchronous reset in the middle of a flow
      wait_idle();
      model_flow(8'd5, 8'd16, 1'b0);
      iFlowIdx = 8'd5;
      iStart   = 1'b1;
      @(posedge iClock); #1;
      check("rst_flow_start_ack", 32'(oStartAck), 32'd1);
      @(negedge iClock);
      iStart = 1'b0;
      @(posedge iClock); #3;
      iReset = 1'b1;
      #1;
      check("midrst_valid", 32'(oUopValid), 32'd0);
      check("midrst_uop", 32'(oUop), 32'd0);
      check("midrst_idle", 32'(oIdle), 32'd1);
      check("midrst_uaddr", 32'(oUaddr), 32'd0);
      check("midrst_stack_err", 32'(oStackErr), 32'd0);
      check("midrst_start_ack", 32'(oStartAck), 32'd0);
      check("midrst_int_ack", 32'(oIntAck), 32'd0);
      exp_w.delete();
      exp_last.delete();
      exp_err = 1'b0;
      @(negedge iClock);
      iReset = 1'b0;

      run_flow(8'd5, 8'd16, 1'b0, 0, 1);
      repeat (2) @(negedge iClock);
      check("scoreboard_drained", 32'(exp_w.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
